// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the DMA memory arbiter
//
// Purpose: arbiter FSM state encoding and burst-source constants.
// Ports:   none (package).
// Config:  none here; see dma_mem_arbiter.sv for DMA_ARB_RR_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_RD   = 2'b01,
    ARB_WR   = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_t;

  // Identifies which requester owns (or last owned) the memory bus.
  localparam logic ARB_SRC_RD = 1'b0;
  localparam logic ARB_SRC_WR = 1'b1;

endpackage

// File: rtl/dma_mem_arbiter_if.sv
// rtl/dma_mem_arbiter_if.sv - requester and memory bus bundle for dma_mem_arbiter
//
// Purpose: groups the read-requester, write-requester and memory-side signals.
// Ports (signals):
//   rd_ask_i/rd_addr_i/rd_len_i -> rd_grant_o/rd_valid_o/rd_data_o/rd_done_o
//   wr_ask_i/wr_addr_i/wr_len_i/wr_data_i -> wr_ready_o/wr_grant_o/wr_done_o
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o <- mem_ack_i/mem_rdata_i
// Modports: slave = arbiter view, master = requesters + memory view.
interface dma_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              rd_ask_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [LEN_W-1:0]  rd_len_i;
  logic              rd_grant_o;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_done_o;

  logic              wr_ask_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [LEN_W-1:0]  wr_len_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              wr_grant_o;
  logic              wr_done_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  rd_ask_i, rd_addr_i, rd_len_i,
    input  wr_ask_i, wr_addr_i, wr_len_i, wr_data_i,
    input  mem_ack_i, mem_rdata_i,
    output rd_grant_o, rd_valid_o, rd_data_o, rd_done_o,
    output wr_ready_o, wr_grant_o, wr_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output rd_ask_i, rd_addr_i, rd_len_i,
    output wr_ask_i, wr_addr_i, wr_len_i, wr_data_i,
    output mem_ack_i, mem_rdata_i,
    input  rd_grant_o, rd_valid_o, rd_data_o, rd_done_o,
    input  wr_ready_o, wr_grant_o, wr_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/arb_beat_ctr.sv
// rtl/arb_beat_ctr.sv - burst beat counter and address stepper
//
// Purpose: latches start address and beats-1 on i_load, then on each i_adv
//          steps the address by STRIDE bytes (wrapping) and counts the beat.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_load       capture i_addr / i_len, clear the beat count
//   i_addr       burst start address
//   i_len        burst beats-1
//   i_adv        one beat accepted
//   o_addr       current beat address (unmasked)
//   o_last       current beat is the final one of the burst
module arb_beat_ctr #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_len  <= i_len;
      r_cnt  <= '0;
    end else if (i_adv) begin
      r_addr <= r_addr + ADDR_W'(STRIDE);
      r_cnt  <= r_cnt + LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_cnt == r_len);
endmodule

// File: rtl/dma_mem_arbiter.sv
// rtl/dma_mem_arbiter.sv - read/write DMA requester arbiter for one memory port
//
// Purpose: grants the read or write DMA FSM, runs its burst beat by beat on
//          the memory bus, then pulses the matching done for one cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          dma_mem_arbiter_if.slave (requesters + memory bus)
// Config macro: DMA_ARB_RR_EN - on conflict, the requester not served last
//               wins; undefined means read always wins.
module dma_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input logic              clk,
  input logic              reset,
  dma_mem_arbiter_if.slave bus
);
  localparam int STRIDE = DATA_W / 8;
  // Beat addresses are always aligned to the beat width.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRIDE - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  // Owner of the current/last burst; in round-robin mode it is also the
  // last-served flag. Resets to write so read wins the first conflict.
  logic              r_src;
  logic              w_src_nxt;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_busy;
  logic              w_pick_rd;
  logic              w_load;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [LEN_W-1:0]  w_ld_len;
  logic              w_adv;
  logic              w_last;
  logic [ADDR_W-1:0] w_beat_addr;

  assign w_busy = (r_state == ARB_RD) || (r_state == ARB_WR);
  // An ack outside a burst is not a beat.
  assign w_adv  = w_busy && bus.mem_ack_i;

`ifdef DMA_ARB_RR_EN
  assign w_pick_rd = bus.rd_ask_i && (!bus.wr_ask_i || (r_src == ARB_SRC_WR));
`else
  assign w_pick_rd = bus.rd_ask_i;
`endif

  arb_beat_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STRIDE (STRIDE)
  ) u_beat_ctr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_addr (w_ld_addr),
    .i_len  (w_ld_len),
    .i_adv  (w_adv),
    .o_addr (w_beat_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_src      <= ARB_SRC_WR;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_rd_valid <= bus.mem_ack_i && (r_state == ARB_RD);
      if (bus.mem_ack_i && (r_state == ARB_RD)) begin
        r_rd_data <= bus.mem_rdata_i;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_load          = 1'b0;
    w_ld_addr       = bus.rd_addr_i;
    w_ld_len        = bus.rd_len_i;
    bus.rd_grant_o  = 1'b0;
    bus.wr_grant_o  = 1'b0;
    bus.rd_done_o   = 1'b0;
    bus.wr_done_o   = 1'b0;
    bus.wr_ready_o  = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.rd_valid_o  = r_rd_valid;
    bus.rd_data_o   = r_rd_data;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_rd) begin
          w_state_nxt = ARB_RD;
          w_src_nxt   = ARB_SRC_RD;
          w_load      = 1'b1;
        end else if (bus.wr_ask_i) begin
          w_state_nxt = ARB_WR;
          w_src_nxt   = ARB_SRC_WR;
          w_load      = 1'b1;
          w_ld_addr   = bus.wr_addr_i;
          w_ld_len    = bus.wr_len_i;
        end
      end
      ARB_RD: begin
        bus.rd_grant_o = 1'b1;
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = w_beat_addr & ADDR_MASK;
        if (bus.mem_ack_i && w_last) begin
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_WR: begin
        bus.wr_grant_o  = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = w_beat_addr & ADDR_MASK;
        bus.mem_wdata_o = bus.wr_data_i;
        bus.wr_ready_o  = bus.mem_ack_i;
        if (bus.mem_ack_i && w_last) begin
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        bus.rd_done_o = (r_src == ARB_SRC_RD);
        bus.wr_done_o = (r_src == ARB_SRC_WR);
        w_state_nxt   = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_mem_arbiter.sv
// tb/tb_dma_mem_arbiter.sv - directed self-checking bench for dma_mem_arbiter
module tb_dma_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dma_mem_arbiter_if bus_if ();

  dma_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  wire [103:0] outs = {bus_if.rd_grant_o, bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.rd_done_o,
                       bus_if.wr_ready_o, bus_if.wr_grant_o, bus_if.wr_done_o, bus_if.mem_req_o,
                       bus_if.mem_we_o, bus_if.mem_addr_o, bus_if.mem_wdata_o};

  always @(negedge clk) begin
    n_cmp++;
    if ((bus_if.rd_grant_o & bus_if.wr_grant_o) !== 1'b0) begin
      n_bad++;
      $display("FAIL grant_exclusive: rd_grant=%b wr_grant=%b want not both 1", bus_if.rd_grant_o, bus_if.wr_grant_o);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus_if.rd_ask_i = 1'b1; bus_if.rd_addr_i = 32'h40; bus_if.rd_len_i = 4'd0;
    bus_if.wr_ask_i = 1'b1; bus_if.wr_addr_i = 32'h80; bus_if.wr_len_i = 4'd0;
    bus_if.wr_data_i = 32'h1234_5678; bus_if.mem_ack_i = 1'b0; bus_if.mem_rdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== '0) begin n_bad++; $display("FAIL reset_outs[%0d]: got %h want 0", i, outs); end
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.rd_grant_o, bus_if.wr_grant_o, bus_if.mem_req_o, bus_if.mem_addr_o} !== {3'b101, 32'h40}) begin
      n_bad++;
      $display("FAIL reset_first_grant: got rg=%b wg=%b req=%b addr=%h want 1 0 1 00000040",
               bus_if.rd_grant_o, bus_if.wr_grant_o, bus_if.mem_req_o, bus_if.mem_addr_o);
    end
    bus_if.rd_ask_i = 1'b0; bus_if.wr_ask_i = 1'b0;
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h5555_0000;
    @(negedge clk);
    bus_if.mem_ack_i = 1'b0;
    n_cmp++;
    if ({bus_if.rd_done_o, bus_if.rd_valid_o, bus_if.rd_data_o} !== {2'b11, 32'h5555_0000}) begin
      n_bad++;
      $display("FAIL reset_burst_done: got done=%b valid=%b data=%h want 1 1 55550000",
               bus_if.rd_done_o, bus_if.rd_valid_o, bus_if.rd_data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_read_burst();
    bus_if.rd_ask_i = 1'b1; bus_if.rd_addr_i = 32'h100; bus_if.rd_len_i = 4'd3;
    @(negedge clk);
    bus_if.rd_ask_i = 1'b0;
    n_cmp++;
    if ({bus_if.rd_grant_o, bus_if.mem_req_o, bus_if.mem_we_o, bus_if.mem_addr_o} !== {3'b110, 32'h100}) begin
      n_bad++;
      $display("FAIL rd_start: got rg=%b req=%b we=%b addr=%h want 1 1 0 00000100",
               bus_if.rd_grant_o, bus_if.mem_req_o, bus_if.mem_we_o, bus_if.mem_addr_o);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'hA000_0000;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_addr_o, bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.rd_done_o} !==
          {32'h100 + 32'(4 * k), 1'b1, 32'hA000_0000 + 32'(k - 1), 1'b0}) begin
        n_bad++;
        $display("FAIL rd_beat[%0d]: got addr=%h valid=%b data=%h done=%b want addr=%h 1 data=%h 0", k,
                 bus_if.mem_addr_o, bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.rd_done_o,
                 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k - 1));
      end
      bus_if.mem_rdata_i = 32'hA000_0000 + 32'(k);
    end
    @(negedge clk);
    bus_if.mem_ack_i = 1'b0;
    n_cmp++;
    if ({bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.rd_done_o, bus_if.rd_grant_o, bus_if.mem_req_o} !==
        {1'b1, 32'hA000_0003, 3'b100}) begin
      n_bad++;
      $display("FAIL rd_last: got valid=%b data=%h done=%b rg=%b req=%b want 1 a0000003 1 0 0",
               bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.rd_done_o, bus_if.rd_grant_o, bus_if.mem_req_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_if.rd_valid_o, bus_if.rd_done_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_after_done: got valid=%b done=%b want 0 0", bus_if.rd_valid_o, bus_if.rd_done_o);
    end
  endtask

  task automatic test_write_wait();
    int req_cycles = 0;
    bus_if.wr_ask_i = 1'b1; bus_if.wr_addr_i = 32'h200; bus_if.wr_len_i = 4'd0;
    bus_if.wr_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.wr_ask_i = 1'b0;
    n_cmp++;
    if ({bus_if.wr_grant_o, bus_if.mem_we_o, bus_if.mem_addr_o, bus_if.mem_wdata_o, bus_if.wr_ready_o} !==
        {2'b11, 32'h200, 32'hDEAD_BEEF, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_start: got wg=%b we=%b addr=%h wdata=%h ready=%b want 1 1 00000200 deadbeef 0",
               bus_if.wr_grant_o, bus_if.mem_we_o, bus_if.mem_addr_o, bus_if.mem_wdata_o, bus_if.wr_ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) bus_if.mem_ack_i = 1'b1;
      #1;
      if (bus_if.mem_req_o === 1'b1) req_cycles++;
      n_cmp++;
      if ({bus_if.mem_we_o, bus_if.wr_ready_o} !== {1'b1, c == 2}) begin
        n_bad++;
        $display("FAIL wr_wait[%0d]: got we=%b ready=%b want 1 %b", c, bus_if.mem_we_o, bus_if.wr_ready_o, c == 2);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (req_cycles !== 3) begin
      n_bad++;
      $display("FAIL wr_req_cycles: got %0d want 3", req_cycles);
    end
    n_cmp++;
    if ({bus_if.wr_done_o, bus_if.wr_grant_o, bus_if.mem_req_o, bus_if.mem_we_o, bus_if.wr_ready_o} !== 5'b10000) begin
      n_bad++;
      $display("FAIL wr_done: got done=%b wg=%b req=%b we=%b ready=%b want 1 0 0 0 0",
               bus_if.wr_done_o, bus_if.wr_grant_o, bus_if.mem_req_o, bus_if.mem_we_o, bus_if.wr_ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_if.wr_done_o, bus_if.wr_ready_o, bus_if.rd_valid_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL wr_idle_ack_ignored: got done=%b ready=%b rvalid=%b want 0 0 0",
               bus_if.wr_done_o, bus_if.wr_ready_o, bus_if.rd_valid_o);
    end
    bus_if.mem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conflict();
    logic [2:0] exp_rd;
`ifdef DMA_ARB_RR_EN
    exp_rd = 3'b101;
`else
    exp_rd = 3'b111;
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_if.rd_addr_i = 32'h500; bus_if.rd_len_i = 4'd0;
    bus_if.wr_addr_i = 32'h600; bus_if.wr_len_i = 4'd0;
    for (int r = 0; r < 3; r++) begin
      bus_if.rd_ask_i = 1'b1; bus_if.wr_ask_i = 1'b1;
      @(negedge clk);
      bus_if.rd_ask_i = 1'b0; bus_if.wr_ask_i = 1'b0;
      n_cmp++;
      if ({bus_if.rd_grant_o, bus_if.wr_grant_o} !== {exp_rd[r], ~exp_rd[r]}) begin
        n_bad++;
        $display("FAIL conflict[%0d]: got rg=%b wg=%b want %b %b", r,
                 bus_if.rd_grant_o, bus_if.wr_grant_o, exp_rd[r], ~exp_rd[r]);
      end
      bus_if.mem_ack_i = 1'b1;
      @(negedge clk);
      bus_if.mem_ack_i = 1'b0;
      n_cmp++;
      if ({bus_if.rd_done_o, bus_if.wr_done_o} !== {exp_rd[r], ~exp_rd[r]}) begin
        n_bad++;
        $display("FAIL conflict_done[%0d]: got rd=%b wd=%b want %b %b", r,
                 bus_if.rd_done_o, bus_if.wr_done_o, exp_rd[r], ~exp_rd[r]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_wrap();
    bus_if.rd_ask_i = 1'b1; bus_if.rd_addr_i = 32'hFFFF_FFFC; bus_if.rd_len_i = 4'd1;
    @(negedge clk);
    bus_if.rd_ask_i = 1'b0;
    n_cmp++;
    if (bus_if.mem_addr_o !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_first: got %h want fffffffc", bus_if.mem_addr_o);
    end
    bus_if.mem_ack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_req_o, bus_if.mem_addr_o} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL wrap_second: got req=%b addr=%h want 1 00000000", bus_if.mem_req_o, bus_if.mem_addr_o);
    end
    @(negedge clk);
    bus_if.mem_ack_i = 1'b0;
    n_cmp++;
    if (bus_if.rd_done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_done: got %b want 1", bus_if.rd_done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bus_if.rd_ask_i = 1'b1; bus_if.rd_addr_i = 32'h300; bus_if.rd_len_i = 4'd3;
    @(negedge clk);
    bus_if.rd_ask_i = 1'b0;
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h0000_0C01;
    repeat (2) @(negedge clk);
    reset = 1'b1; bus_if.mem_ack_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL midrst_outs: got %h want 0", outs); end
    @(negedge clk);
    n_cmp++;
    if ({bus_if.rd_done_o, bus_if.rd_grant_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_no_done: got done=%b rg=%b want 0 0", bus_if.rd_done_o, bus_if.rd_grant_o);
    end
    bus_if.rd_ask_i = 1'b1; bus_if.rd_addr_i = 32'h400; bus_if.rd_len_i = 4'd1;
    @(negedge clk);
    bus_if.rd_ask_i = 1'b0;
    n_cmp++;
    if ({bus_if.rd_grant_o, bus_if.mem_addr_o} !== {1'b1, 32'h400}) begin
      n_bad++;
      $display("FAIL midrst_restart: got rg=%b addr=%h want 1 00000400", bus_if.rd_grant_o, bus_if.mem_addr_o);
    end
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'hBEEF_0000;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_addr_o, bus_if.rd_valid_o, bus_if.rd_data_o} !== {32'h404, 1'b1, 32'hBEEF_0000}) begin
      n_bad++;
      $display("FAIL midrst_beat0: got addr=%h valid=%b data=%h want 00000404 1 beef0000",
               bus_if.mem_addr_o, bus_if.rd_valid_o, bus_if.rd_data_o);
    end
    bus_if.mem_rdata_i = 32'hBEEF_0001;
    @(negedge clk);
    bus_if.mem_ack_i = 1'b0;
    n_cmp++;
    if ({bus_if.rd_done_o, bus_if.rd_valid_o, bus_if.rd_data_o} !== {2'b11, 32'hBEEF_0001}) begin
      n_bad++;
      $display("FAIL midrst_done: got done=%b valid=%b data=%h want 1 1 beef0001",
               bus_if.rd_done_o, bus_if.rd_valid_o, bus_if.rd_data_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_wait();
    test_conflict();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
